// File: rtl/glyph_row_renderer_pkg.sv
// Shared VGA/glyph definitions: pixel-write mode encodings, screen limits,
// colour constants, FSM state type and a counter-width helper.
package glyph_row_renderer_pkg;

    localparam logic [1:0] MODE_TRANSPARENT = 2'b00;
    localparam logic [1:0] MODE_OPAQUE      = 2'b01;
    localparam logic [1:0] MODE_CLEAR       = 2'b10;

    localparam int SCREEN_X_MAX = 159;
    localparam int SCREEN_Y_MAX = 119;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] GREEN = 3'b010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_DRAW = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/glyph_row_renderer_if.sv
// Handshake and pixel-bus bundle of the glyph row renderer.
//   master : the requester (decode logic / bench) driving operands and start
//   slave  : the renderer, driving busy/done and the VGA pixel-write signals
interface glyph_row_renderer_if #(
    parameter int NUM_GLYPHS = 3,
    parameter int GLYPH_W    = 12,
    parameter int GLYPH_H    = 12
);
    logic                                   start;
    logic                                   abort;
    logic [1:0]                             mode;
    logic [7:0]                             x;
    logic [6:0]                             y;
    logic [2:0]                             fg;
    logic [2:0]                             bg;
    logic [NUM_GLYPHS*GLYPH_W*GLYPH_H-1:0]  glyphs;
    logic                                   busy;
    logic                                   done;
    logic [7:0]                             x_out;
    logic [6:0]                             y_out;
    logic [2:0]                             colour;
    logic                                   writeEn;

    modport master (
        output start, abort, mode, x, y, fg, bg, glyphs,
        input  busy, done, x_out, y_out, colour, writeEn
    );

    modport slave (
        input  start, abort, mode, x, y, fg, bg, glyphs,
        output busy, done, x_out, y_out, colour, writeEn
    );

endinterface

// File: rtl/glyph_row_renderer_counter.sv
// glyph_raster_counter: nested glyph / row / column scan counter.
// Ports: clk, rst_n (async active-low), clear_i (synchronous zero),
//        advance_i (step one pixel), k_o/row_o/col_o (current position),
//        last_o (position is the final pixel of the last glyph).
module glyph_raster_counter
    import glyph_row_renderer_pkg::*;
#(
    parameter  int NUM_GLYPHS = 3,
    parameter  int GLYPH_W    = 12,
    parameter  int GLYPH_H    = 12,
    localparam int KW         = cnt_width(NUM_GLYPHS),
    localparam int RW         = cnt_width(GLYPH_H),
    localparam int CW         = cnt_width(GLYPH_W)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [KW-1:0] k_o,
    output logic [RW-1:0] row_o,
    output logic [CW-1:0] col_o,
    output logic          last_o
);

    localparam logic [KW-1:0] K_LAST = KW'(NUM_GLYPHS - 1);
    localparam logic [RW-1:0] R_LAST = RW'(GLYPH_H - 1);
    localparam logic [CW-1:0] C_LAST = CW'(GLYPH_W - 1);

    logic [KW-1:0] k_q;
    logic [RW-1:0] row_q;
    logic [CW-1:0] col_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q   <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (clear_i) begin
            k_q   <= '0;
            row_q <= '0;
            col_q <= '0;
        end else if (advance_i) begin
            if (col_q == C_LAST) begin
                col_q <= '0;
                if (row_q == R_LAST) begin
                    row_q <= '0;
                    k_q   <= (k_q == K_LAST) ? '0 : k_q + KW'(1);
                end else begin
                    row_q <= row_q + RW'(1);
                end
            end else begin
                col_q <= col_q + CW'(1);
            end
        end
    end

    assign k_o    = k_q;
    assign row_o  = row_q;
    assign col_o  = col_q;
    assign last_o = (k_q == K_LAST) && (row_q == R_LAST) && (col_q == C_LAST);

endmodule

// File: rtl/glyph_row_renderer.sv
// glyph_row_renderer: rasterises a row of NUM_GLYPHS monochrome bitmaps into
// the VGA adapter pixel-write bus, one pixel per clock, with clipping,
// transparent/opaque/clear modes and abort.
// Ports: clk, reset (async active-low), bus (slave side of
//        glyph_row_renderer_if: start/abort/operands in, busy/done/pixel out).
//
// state   | meaning
// --------+-----------------------------------------------------------
// ST_IDLE | waiting for start; operands latched on acceptance
// ST_DRAW | counters hold the pixel being emitted on the next clock
// ST_DONE | last pixel already on the bus; done pulses on the next clock
module glyph_row_renderer
    import glyph_row_renderer_pkg::*;
#(
    parameter int NUM_GLYPHS = 3,
    parameter int GLYPH_W    = 12,
    parameter int GLYPH_H    = 12,
    parameter int GAP        = 0,
    parameter int X_MAX      = SCREEN_X_MAX,
    parameter int Y_MAX      = SCREEN_Y_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    glyph_row_renderer_if.slave  bus
);

    localparam int GSZ   = GLYPH_W * GLYPH_H;
    localparam int TOTAL = NUM_GLYPHS * GSZ;
    localparam int KW    = cnt_width(NUM_GLYPHS);
    localparam int RW    = cnt_width(GLYPH_H);
    localparam int CW    = cnt_width(GLYPH_W);
    localparam int IW    = cnt_width(TOTAL);
    localparam logic [15:0] PITCH = 16'(GLYPH_W + GAP);

    state_t state_q, state_d;

    logic [1:0]       mode_q;
    logic [7:0]       x_q;
    logic [6:0]       y_q;
    logic [2:0]       fg_q, bg_q;
    logic [TOTAL-1:0] glyphs_q;

    logic [KW-1:0] cnt_k;
    logic [RW-1:0] cnt_row;
    logic [CW-1:0] cnt_col;
    logic          cnt_last;

    logic          start_acc;
    logic          advance;

    logic [IW-1:0] bit_idx;
    logic          pix_bit;
    logic [15:0]   x_calc;
    logic [7:0]    y_calc;
    logic          clipped;

    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       we_q, we_d;
    logic [7:0] x_out_q, x_out_d;
    logic [6:0] y_out_q, y_out_d;
    logic [2:0] colour_q, colour_d;

    assign start_acc = (state_q == ST_IDLE) && bus.start;
    assign advance   = (state_q == ST_DRAW) && !bus.abort && !cnt_last;

    glyph_raster_counter #(
        .NUM_GLYPHS (NUM_GLYPHS),
        .GLYPH_W    (GLYPH_W),
        .GLYPH_H    (GLYPH_H)
    ) u_cnt (
        .clk       (clk),
        .rst_n     (reset),
        .clear_i   (start_acc),
        .advance_i (advance),
        .k_o       (cnt_k),
        .row_o     (cnt_row),
        .col_o     (cnt_col),
        .last_o    (cnt_last)
    );

    // Operand latch; mode 11 is folded to transparent here so the output
    // logic only ever sees the three real modes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q   <= MODE_TRANSPARENT;
            x_q      <= '0;
            y_q      <= '0;
            fg_q     <= '0;
            bg_q     <= '0;
            glyphs_q <= '0;
        end else if (start_acc) begin
            mode_q   <= (bus.mode == 2'b11) ? MODE_TRANSPARENT : bus.mode;
            x_q      <= bus.x;
            y_q      <= bus.y;
            fg_q     <= bus.fg;
            bg_q     <= bus.bg;
            glyphs_q <= bus.glyphs;
        end
    end

    // MSB of each glyph slice is its top-left pixel.
    always_comb begin
        bit_idx = IW'(int'(cnt_k) * GSZ + (GSZ - 1)
                      - (int'(cnt_row) * GLYPH_W + int'(cnt_col)));
        pix_bit = glyphs_q[bit_idx];
        // Coordinates are kept wide so the clip test sees the true position
        // before truncation to the bus widths.
        x_calc  = 16'(x_q) + PITCH * 16'(cnt_k) + 16'(cnt_col);
        y_calc  = 8'(y_q) + 8'(cnt_row);
        clipped = (x_calc > 16'(X_MAX)) || (y_calc > 8'(Y_MAX));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.start) state_d = ST_DRAW;
            ST_DRAW: begin
                if (bus.abort)     state_d = ST_IDLE;
                else if (cnt_last) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // busy follows the next state so it rises the cycle after start and
    // falls together with the last pixel; done trails DONE by one register.
    always_comb begin
        busy_d   = (state_d == ST_DRAW);
        done_d   = (state_q == ST_DONE);
        we_d     = 1'b0;
        x_out_d  = x_out_q;
        y_out_d  = y_out_q;
        colour_d = colour_q;
        if (state_q == ST_DRAW && !bus.abort) begin
            x_out_d = x_calc[7:0];
            y_out_d = y_calc[6:0];
            if (!clipped) begin
                case (mode_q)
                    MODE_OPAQUE: begin
                        we_d     = 1'b1;
                        colour_d = pix_bit ? fg_q : bg_q;
                    end
                    MODE_CLEAR: begin
                        we_d     = 1'b1;
                        colour_d = bg_q;
                    end
                    default: begin
                        we_d = pix_bit;
                        if (pix_bit) colour_d = fg_q;
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            we_q     <= 1'b0;
            x_out_q  <= '0;
            y_out_q  <= '0;
            colour_q <= '0;
        end else begin
            busy_q   <= busy_d;
            done_q   <= done_d;
            we_q     <= we_d;
            x_out_q  <= x_out_d;
            y_out_q  <= y_out_d;
            colour_q <= colour_d;
        end
    end

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.writeEn = we_q;
    assign bus.x_out   = x_out_q;
    assign bus.y_out   = y_out_q;
    assign bus.colour  = colour_q;

endmodule

// File: tb/tb_glyph_row_renderer.sv
// Self-checking bench for glyph_row_renderer. Three instances: default
// geometry (A), 4 glyphs of 8x8 with GAP=2 (B), single 12x12 glyph (C).
// A reference model pushes every expected pixel write into a queue; the
// monitor pops and compares on each observed write.
module tb_glyph_row_renderer;
    import glyph_row_renderer_pkg::*;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
    } pix_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         tb_start = 1'b0;
    logic         tb_abort = 1'b0;
    logic [1:0]   tb_mode = 2'b00;
    logic [7:0]   tb_x = '0;
    logic [6:0]   tb_y = '0;
    logic [2:0]   tb_fg = '0;
    logic [2:0]   tb_bg = '0;
    logic [431:0] tb_glyphs = '0;
    int           sel = 0;

    int   n_checks = 0;
    int   n_pass = 0;
    int   wr_cnt = 0;
    pix_t q_exp[$];
    pix_t mon_e;

    glyph_row_renderer_if #(.NUM_GLYPHS(3), .GLYPH_W(12), .GLYPH_H(12)) bus_a ();
    glyph_row_renderer_if #(.NUM_GLYPHS(4), .GLYPH_W(8),  .GLYPH_H(8))  bus_b ();
    glyph_row_renderer_if #(.NUM_GLYPHS(1), .GLYPH_W(12), .GLYPH_H(12)) bus_c ();

    assign bus_a.start = tb_start && (sel == 0);
    assign bus_a.abort = tb_abort && (sel == 0);
    assign bus_a.mode = tb_mode;
    assign bus_a.x = tb_x;
    assign bus_a.y = tb_y;
    assign bus_a.fg = tb_fg;
    assign bus_a.bg = tb_bg;
    assign bus_a.glyphs = tb_glyphs;

    assign bus_b.start = tb_start && (sel == 1);
    assign bus_b.abort = tb_abort && (sel == 1);
    assign bus_b.mode = tb_mode;
    assign bus_b.x = tb_x;
    assign bus_b.y = tb_y;
    assign bus_b.fg = tb_fg;
    assign bus_b.bg = tb_bg;
    assign bus_b.glyphs = tb_glyphs[255:0];

    assign bus_c.start = tb_start && (sel == 2);
    assign bus_c.abort = tb_abort && (sel == 2);
    assign bus_c.mode = tb_mode;
    assign bus_c.x = tb_x;
    assign bus_c.y = tb_y;
    assign bus_c.fg = tb_fg;
    assign bus_c.bg = tb_bg;
    assign bus_c.glyphs = tb_glyphs[143:0];

    glyph_row_renderer #(.NUM_GLYPHS(3), .GLYPH_W(12), .GLYPH_H(12), .GAP(0))
        dut_a (.clk(clk), .reset(rst_n), .bus(bus_a));
    glyph_row_renderer #(.NUM_GLYPHS(4), .GLYPH_W(8), .GLYPH_H(8), .GAP(2))
        dut_b (.clk(clk), .reset(rst_n), .bus(bus_b));
    glyph_row_renderer #(.NUM_GLYPHS(1), .GLYPH_W(12), .GLYPH_H(12), .GAP(0))
        dut_c (.clk(clk), .reset(rst_n), .bus(bus_c));

    logic       m_busy, m_done, m_we;
    logic [7:0] m_x;
    logic [6:0] m_y;
    logic [2:0] m_col;

    always_comb begin
        case (sel)
            1:       {m_busy, m_done, m_we, m_x, m_y, m_col} = {bus_b.busy, bus_b.done, bus_b.writeEn, bus_b.x_out, bus_b.y_out, bus_b.colour};
            2:       {m_busy, m_done, m_we, m_x, m_y, m_col} = {bus_c.busy, bus_c.done, bus_c.writeEn, bus_c.x_out, bus_c.y_out, bus_c.colour};
            default: {m_busy, m_done, m_we, m_x, m_y, m_col} = {bus_a.busy, bus_a.done, bus_a.writeEn, bus_a.x_out, bus_a.y_out, bus_a.colour};
        endcase
    end

    always @(negedge clk) begin
        if (m_we === 1'b1) begin
            wr_cnt++;
            n_checks++;
            if (q_exp.size() == 0) begin
                $display("FAIL extra_write: got write x=%0d y=%0d colour=%0d, required no write", m_x, m_y, m_col);
            end else begin
                mon_e = q_exp.pop_front();
                if ({m_x, m_y, m_col} !== mon_e)
                    $display("FAIL pixel_write: got x=%0d y=%0d colour=%0d, required x=%0d y=%0d colour=%0d",
                             m_x, m_y, m_col, mon_e.x, mon_e.y, mon_e.c);
                else
                    n_pass++;
            end
        end
    end

    localparam logic [143:0] G_A = {12'h060, 12'h0F0, 12'h198, 12'h30C, 12'h30C, 12'h606,
                                    12'h7FE, 12'h7FE, 12'hC03, 12'hC03, 12'hC03, 12'h000};
    localparam logic [143:0] G_H = {12'h198, 12'h198, 12'hFFF, 12'h198, 12'h198, 12'h198,
                                    12'hFFF, 12'h198, 12'h198, 12'h198, 12'h000, 12'h000};
    localparam logic [143:0] G_2 = {12'h3FC, 12'h606, 12'h006, 12'h00C, 12'h018, 12'h030,
                                    12'h060, 12'h0C0, 12'h180, 12'h300, 12'h7FE, 12'h000};

    // cut_kind: 0 full draw, 1 abort at edge cut_at, 2 reset at edge cut_at.
    // Edge 0 is the clock that accepts start; pixel p is on the bus after edge p+1.
    task automatic run_draw(input int s, input logic [1:0] md, input int xi, input int yi,
                            input logic [2:0] f, input logic [2:0] b,
                            input int cut_kind, input int cut_at, input int restart_at,
                            input int gchg_at, input int probe1, input int probe2,
                            output int done_edge, output int busy_cnt, output int done_cnt,
                            output int n_exp, output logic [14:0] p1, output logic [14:0] p2,
                            output logic [20:0] snap);
        int ng, gw, gh, gap, n, lim, end_at, edges, idx, px, py, em;
        logic bitv;
        pix_t e;
        ng = (s == 1) ? 4 : (s == 2) ? 1 : 3;
        gw = (s == 1) ? 8 : 12;
        gh = (s == 1) ? 8 : 12;
        gap = (s == 1) ? 2 : 0;
        n = ng * gw * gh;
        lim = (cut_kind != 0) ? cut_at : n;
        em = (md == 2'b11) ? 0 : int'(md);
        n_exp = 0;
        for (int k = 0; k < ng; k++)
            for (int r = 0; r < gh; r++)
                for (int c = 0; c < gw; c++) begin
                    idx = (k * gh + r) * gw + c;
                    bitv = tb_glyphs[k * gw * gh + gw * gh - 1 - (r * gw + c)];
                    px = xi + k * (gw + gap) + c;
                    py = yi + r;
                    if (idx < lim && px <= 159 && py <= 119) begin
                        e.x = px[7:0];
                        e.y = py[6:0];
                        if (em == 1) begin
                            e.c = bitv ? f : b;
                            q_exp.push_back(e); n_exp++;
                        end else if (em == 2) begin
                            e.c = b;
                            q_exp.push_back(e); n_exp++;
                        end else if (bitv) begin
                            e.c = f;
                            q_exp.push_back(e); n_exp++;
                        end
                    end
                end
        done_edge = -1; busy_cnt = 0; done_cnt = 0; p1 = '0; p2 = '0; snap = '1;
        end_at = (cut_kind != 0) ? cut_at + 8 : n + 8;
        @(negedge clk);
        sel = s;
        tb_mode = md; tb_x = xi[7:0]; tb_y = yi[6:0]; tb_fg = f; tb_bg = b;
        wr_cnt = 0;
        tb_start = 1'b1;
        @(posedge clk);
        edges = 0;
        while (edges < end_at) begin
            @(negedge clk);
            tb_start = 1'b0;
            tb_abort = 1'b0;
            if (m_busy === 1'b1) busy_cnt++;
            if (m_done === 1'b1) begin
                done_cnt++;
                if (done_edge < 0) done_edge = edges;
            end
            if (edges == probe1) p1 = {m_x, m_y};
            if (edges == probe2) p2 = {m_x, m_y};
            if (edges == restart_at) begin
                tb_start = 1'b1;
                tb_x = tb_x + 8'd7;
            end
            if (edges == gchg_at) tb_glyphs = ~tb_glyphs;
            if (cut_kind == 1 && edges == cut_at) tb_abort = 1'b1;
            if (cut_kind == 1 && edges == cut_at + 1) snap = {m_busy, m_done, m_we, m_x, m_y, m_col};
            if (cut_kind == 2 && edges == cut_at) begin
                #1 rst_n = 1'b0;
                #1 snap = {m_busy, m_done, m_we, m_x, m_y, m_col};
                break;
            end
            @(posedge clk);
            edges++;
        end
    endtask

    int de, bc, dc, ne;
    logic [14:0] p1, p2;
    logic [20:0] snap;

    task automatic test_reset();
        rst_n = 1'b0;
        sel = 0;
        repeat (3) @(negedge clk);
        n_checks++; if (m_busy !== 1'b0) $display("FAIL reset_busy: got %0b, required 0", m_busy); else n_pass++;
        n_checks++; if (m_done !== 1'b0) $display("FAIL reset_done: got %0b, required 0", m_done); else n_pass++;
        n_checks++; if (m_we !== 1'b0) $display("FAIL reset_we: got %0b, required 0", m_we); else n_pass++;
        n_checks++; if ({m_x, m_y, m_col} !== 18'd0) $display("FAIL reset_pixel: got x=%0d y=%0d c=%0d, required 0 0 0", m_x, m_y, m_col); else n_pass++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_transparent();
        tb_glyphs = {G_2, G_H, G_A};
        run_draw(0, 2'b00, 10, 20, 3'd5, 3'd2, 0, 0, -1, -1, 1, 432, de, bc, dc, ne, p1, p2, snap);
        n_checks++; if (de != 433) $display("FAIL tr_done_edge: got %0d, required 433", de); else n_pass++;
        n_checks++; if (bc != 432) $display("FAIL tr_busy_cycles: got %0d, required 432", bc); else n_pass++;
        n_checks++; if (dc != 1) $display("FAIL tr_done_count: got %0d, required 1", dc); else n_pass++;
        n_checks++; if (p1 !== {8'd10, 7'd20}) $display("FAIL tr_first_pixel: got x=%0d y=%0d, required 10 20", p1[14:7], p1[6:0]); else n_pass++;
        n_checks++; if (p2 !== {8'd45, 7'd31}) $display("FAIL tr_last_pixel: got x=%0d y=%0d, required 45 31", p2[14:7], p2[6:0]); else n_pass++;
        n_checks++; if (wr_cnt != ne) $display("FAIL tr_write_count: got %0d, required %0d", wr_cnt, ne); else n_pass++;
        n_checks++; if (q_exp.size() != 0) $display("FAIL tr_missing_writes: got %0d left, required 0", q_exp.size()); else n_pass++;
        q_exp.delete();
    endtask

    task automatic test_opaque_clear();
        tb_glyphs = '0;
        run_draw(2, 2'b01, 30, 40, GREEN, BLACK, 0, 0, -1, -1, -1, -1, de, bc, dc, ne, p1, p2, snap);
        n_checks++; if (wr_cnt != 144) $display("FAIL op_write_count: got %0d, required 144", wr_cnt); else n_pass++;
        n_checks++; if (de != 145) $display("FAIL op_done_edge: got %0d, required 145", de); else n_pass++;
        n_checks++; if (q_exp.size() != 0) $display("FAIL op_missing_writes: got %0d left, required 0", q_exp.size()); else n_pass++;
        q_exp.delete();
        tb_glyphs = '1;
        run_draw(2, 2'b10, 5, 6, 3'd7, 3'd3, 0, 0, -1, -1, -1, -1, de, bc, dc, ne, p1, p2, snap);
        n_checks++; if (wr_cnt != 144) $display("FAIL clr_write_count: got %0d, required 144", wr_cnt); else n_pass++;
        n_checks++; if (q_exp.size() != 0) $display("FAIL clr_missing_writes: got %0d left, required 0", q_exp.size()); else n_pass++;
        q_exp.delete();
    endtask

    task automatic test_clipping();
        tb_glyphs = {G_2, G_H, G_A};
        run_draw(0, 2'b01, 150, 115, 3'd6, 3'd1, 0, 0, -1, -1, -1, -1, de, bc, dc, ne, p1, p2, snap);
        n_checks++; if (wr_cnt != 50) $display("FAIL clip_write_count: got %0d, required 50", wr_cnt); else n_pass++;
        n_checks++; if (de != 433) $display("FAIL clip_done_edge: got %0d, required 433", de); else n_pass++;
        n_checks++; if (bc != 432) $display("FAIL clip_busy_cycles: got %0d, required 432", bc); else n_pass++;
        n_checks++; if (q_exp.size() != 0) $display("FAIL clip_missing_writes: got %0d left, required 0", q_exp.size()); else n_pass++;
        q_exp.delete();
    endtask

    task automatic test_restart_ignored();
        tb_glyphs = {G_2, G_H, G_A};
        run_draw(0, 2'b00, 12, 5, 3'd4, 3'd0, 0, 0, 50, 60, -1, -1, de, bc, dc, ne, p1, p2, snap);
        n_checks++; if (dc != 1) $display("FAIL rs_done_count: got %0d, required 1", dc); else n_pass++;
        n_checks++; if (de != 433) $display("FAIL rs_done_edge: got %0d, required 433", de); else n_pass++;
        n_checks++; if (q_exp.size() != 0) $display("FAIL rs_missing_writes: got %0d left, required 0", q_exp.size()); else n_pass++;
        q_exp.delete();
    endtask

    task automatic test_abort();
        tb_glyphs = {G_2, G_H, G_A};
        run_draw(0, 2'b01, 0, 0, 3'd3, 3'd4, 1, 100, -1, -1, -1, -1, de, bc, dc, ne, p1, p2, snap);
        n_checks++; if (snap[20] !== 1'b0) $display("FAIL ab_busy: got %0b, required 0", snap[20]); else n_pass++;
        n_checks++; if (snap[18] !== 1'b0) $display("FAIL ab_we: got %0b, required 0", snap[18]); else n_pass++;
        n_checks++; if (dc != 0) $display("FAIL ab_done_count: got %0d, required 0", dc); else n_pass++;
        n_checks++; if (wr_cnt != 100) $display("FAIL ab_write_count: got %0d, required 100", wr_cnt); else n_pass++;
        q_exp.delete();
        run_draw(0, 2'b01, 60, 60, 3'd3, 3'd4, 0, 0, -1, -1, 1, -1, de, bc, dc, ne, p1, p2, snap);
        n_checks++; if (p1 !== {8'd60, 7'd60}) $display("FAIL ab_restart_first: got x=%0d y=%0d, required 60 60", p1[14:7], p1[6:0]); else n_pass++;
        n_checks++; if (de != 433) $display("FAIL ab_restart_done_edge: got %0d, required 433", de); else n_pass++;
        n_checks++; if (q_exp.size() != 0) $display("FAIL ab_restart_missing: got %0d left, required 0", q_exp.size()); else n_pass++;
        q_exp.delete();
    endtask

    task automatic test_reset_mid_draw();
        tb_glyphs = {G_2, G_H, G_A};
        run_draw(0, 2'b00, 10, 20, 3'd5, 3'd2, 2, 60, -1, -1, -1, -1, de, bc, dc, ne, p1, p2, snap);
        n_checks++; if (snap !== 21'd0) $display("FAIL rm_outputs: got %h, required 0", snap); else n_pass++;
        n_checks++; if (q_exp.size() != 0) $display("FAIL rm_missing_writes: got %0d left, required 0", q_exp.size()); else n_pass++;
        q_exp.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        run_draw(1, 2'b00, 20, 30, 3'd6, 3'd1, 0, 0, -1, -1, 193, -1, de, bc, dc, ne, p1, p2, snap);
        n_checks++; if (p1 !== {8'd50, 7'd30}) $display("FAIL gap_glyph3_x: got x=%0d y=%0d, required 50 30", p1[14:7], p1[6:0]); else n_pass++;
        n_checks++; if (de != 257) $display("FAIL gap_done_edge: got %0d, required 257", de); else n_pass++;
        n_checks++; if (bc != 256) $display("FAIL gap_busy_cycles: got %0d, required 256", bc); else n_pass++;
        n_checks++; if (q_exp.size() != 0) $display("FAIL gap_missing_writes: got %0d left, required 0", q_exp.size()); else n_pass++;
        q_exp.delete();
    endtask

    initial begin
        test_reset();
        test_transparent();
        test_opaque_clear();
        test_clipping();
        test_restart_ignored();
        test_abort();
        test_reset_mid_draw();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
